seq_restoring_divider: RTL and testbench

Iterative restoring divider that takes a DIVIDEND_W-bit unsigned dividend and a DIVISOR_W-bit unsigned divisor. It returns the quotient and remainder, producing one quotient bit per clock. It is the inverse-operation companion to the 6x6 Wallace multiplier datapath: it consumes 12-bit products and recovers factors. Valid/ready handshake on both the input and output sides.

---
 rtl/div_pkg.sv | 28 ++
 rtl/div_step.sv | 32 +++
 rtl/seq_restoring_divider.sv | 140 ++++++++++++++
 tb/tb_seq_restoring_divider.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
//------------------------------------------------------------------------------
// Module      : div_pkg
// Description : Shared types and constants for the sequential restoring divider.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package div_pkg;

    localparam int DIV_DIVIDEND_W = 12;
    localparam int DIV_DIVISOR_W  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Counter must be able to hold the value DIVIDEND_W.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int CNT_W = cnt_width(DIV_DIVIDEND_W);

endpackage

`default_nettype wire

// File: rtl/div_step.sv
//------------------------------------------------------------------------------
// Module      : div_step
// Description : One combinational restoring-division step (shift in, trial subtract).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module div_step #(
    parameter int DIVISOR_W = 6
) (
    input  logic [DIVISOR_W:0]   pr,
    input  logic                 in_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   pr_next,
    output logic                 q_bit
);

    logic [DIVISOR_W:0] w_shifted;
    logic [DIVISOR_W:0] w_diff;
    logic               w_unused_pr_msb;

    // After a restoring step pr < divisor, so its MSB is never shifted out.
    assign w_unused_pr_msb = pr[DIVISOR_W];

    assign w_shifted = {pr[DIVISOR_W-1:0], in_bit};
    assign w_diff    = w_shifted - {1'b0, divisor};
    assign q_bit     = (w_shifted >= {1'b0, divisor});
    assign pr_next   = q_bit ? w_diff : w_shifted;

endmodule

`default_nettype wire

// File: rtl/seq_restoring_divider.sv
//------------------------------------------------------------------------------
// Module      : seq_restoring_divider
// Description : Iterative unsigned restoring divider, one quotient bit per clock,
//               valid/ready on both sides. Optional SEQ_RESTORING_DIVIDER_DBZ_EN
//               enables early divide-by-zero completion.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DIV_DIVIDEND_W,
    parameter int DIVISOR_W  = DIV_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int                  c_cnt_w    = cnt_width(DIVIDEND_W);
    localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(DIVIDEND_W - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);

    div_state_t              r_state;
    div_state_t              w_state_next;
    logic [DIVIDEND_W-1:0]   r_q;
    logic [DIVISOR_W:0]      r_pr;
    logic [DIVISOR_W-1:0]    r_divisor;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [DIVISOR_W:0]      w_pr_next;
    logic                    w_q_bit;

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_div_step (
        .pr      (r_pr),
        .in_bit  (r_q[DIVIDEND_W-1]),
        .divisor (r_divisor),
        .pr_next (w_pr_next),
        .q_bit   (w_q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
`ifdef SEQ_RESTORING_DIVIDER_DBZ_EN
                    w_state_next = (divisor == '0) ? DONE : CALC;
`else
                    w_state_next = CALC;
`endif
                end
            end
            CALC: begin
                if (r_cnt == c_cnt_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q       <= '0;
            r_pr      <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_q       <= dividend;
                        r_divisor <= divisor;
                        r_pr      <= '0;
                        r_cnt     <= '0;
`ifdef SEQ_RESTORING_DIVIDER_DBZ_EN
                        if (divisor == '0) begin
                            r_q <= '1;
                        end
`endif
                    end
                end
                CALC: begin
                    r_q   <= {r_q[DIVIDEND_W-2:0], w_q_bit};
                    r_pr  <= w_pr_next;
                    r_cnt <= r_cnt + c_cnt_one;
                end
                default: ;
            endcase
        end
    end

`ifdef SEQ_RESTORING_DIVIDER_DBZ_EN
    logic r_dbz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dbz <= 1'b0;
        end else if (r_state == IDLE && in_valid) begin
            r_dbz <= (divisor == '0);
        end
    end

    assign div_by_zero = r_dbz;
`else
    assign div_by_zero = 1'b0;
`endif

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign quotient  = r_q;
    assign remainder = r_pr[DIVISOR_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
//------------------------------------------------------------------------------
// Module      : tb_seq_restoring_divider
// Description : Table-driven, scoreboarded bench for seq_restoring_divider.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_restoring_divider;

    localparam int DW = 12;
    localparam int SW = 6;

    typedef struct {
        logic [DW-1:0] dividend;
        logic [SW-1:0] divisor;
        logic [DW-1:0] q;
        logic [SW-1:0] r;
        logic          dbz;
        int            hold;
        bit            pulse;
    } vec_t;

    typedef struct {
        logic [DW-1:0] q;
        logic [SW-1:0] r;
        logic          dbz;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [SW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [SW-1:0] remainder;
    logic          div_by_zero;

    int   n_checks;
    int   n_errors;
    exp_t sb[$];
    vec_t vecs[10];

    seq_restoring_divider #(
        .DIVIDEND_W (DW),
        .DIVISOR_W  (SW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),    32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid),   32'd0);
        chk({tag, "_quotient"},  32'(quotient),    32'd0);
        chk({tag, "_remainder"}, 32'(remainder),   32'd0);
        chk({tag, "_dbz"},       32'(div_by_zero), 32'd0);
    endtask

    task automatic run_op(input vec_t v);
        exp_t e;
        int   lat;
        int   exp_lat;
        e.q   = v.q;
        e.r   = v.r;
        e.dbz = v.dbz;
        sb.push_back(e);
        exp_lat = DW + 1;
`ifdef SEQ_RESTORING_DIVIDER_DBZ_EN
        if (v.divisor == '0) exp_lat = 1;
`endif
        dividend  = v.dividend;
        divisor   = v.divisor;
        in_valid  = 1'b1;
        out_ready = (v.hold == 0);
        lat = 0;
        while (!in_ready && lat < 100) begin
            step();
            lat++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            chk("calc_in_ready", 32'(in_ready), 32'd0);
            if (v.pulse && lat == 4) begin
                in_valid = 1'b1;
                dividend = 12'd77;
                divisor  = 6'd3;
            end else begin
                in_valid = 1'b0;
            end
            step();
            lat++;
        end
        in_valid = 1'b0;
        if (!out_valid) begin
            chk("result_timeout", 32'(out_valid), 32'd1);
            void'(sb.pop_front());
            return;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        for (int h = 0; h < v.hold; h++) begin
            step();
            chk("hold_valid",     32'(out_valid), 32'd1);
            chk("hold_quotient",  32'(quotient),  32'(e.q));
            chk("hold_remainder", 32'(remainder), 32'(e.r));
        end
        out_ready = 1'b1;
        e = sb.pop_front();
        chk("quotient",    32'(quotient),    32'(e.q));
        chk("remainder",   32'(remainder),   32'(e.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        step();
        chk("valid_drop",  32'(out_valid), 32'd0);
        chk("ready_again", 32'(in_ready),  32'd1);
    endtask

    initial begin
        vec_t v;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;

        //            dividend  divisor q         r      dbz   hold pulse
        vecs[0] = '{12'd100,  6'd7,  12'd14,   6'd2,  1'b0, 0, 1'b0};
        vecs[1] = '{12'd4095, 6'd63, 12'd65,   6'd0,  1'b0, 0, 1'b0};
        vecs[2] = '{12'd4095, 6'd1,  12'd4095, 6'd0,  1'b0, 0, 1'b0};
        vecs[3] = '{12'd5,    6'd7,  12'd0,    6'd5,  1'b0, 0, 1'b0};
        vecs[4] = '{12'd1000, 6'd50, 12'd20,   6'd0,  1'b0, 5, 1'b0};
`ifdef SEQ_RESTORING_DIVIDER_DBZ_EN
        vecs[5] = '{12'd1234, 6'd0,  12'd4095, 6'd0,  1'b1, 0, 1'b0};
`else
        vecs[5] = '{12'd1234, 6'd0,  12'd4095, 6'd18, 1'b0, 0, 1'b0};
`endif
        vecs[6] = '{12'd12,   6'd3,  12'd4,    6'd0,  1'b0, 0, 1'b1};
        vecs[7] = '{12'd4000, 6'd63, 12'd63,   6'd31, 1'b0, 0, 1'b0};
        vecs[8] = '{12'd0,    6'd5,  12'd0,    6'd0,  1'b0, 0, 1'b0};
        vecs[9] = '{12'd2000, 6'd9,  12'd222,  6'd2,  1'b0, 0, 1'b1};

        #1;
        chk_reset_values("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i]);
        end

        // Asynchronous reset landing in the middle of an iteration.
        dividend  = 12'd2000;
        divisor   = 6'd9;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (6) step();
        chk("mid_calc_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk_reset_values("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        v = '{12'd2000, 6'd9, 12'd222, 6'd2, 1'b0, 0, 1'b0};
        run_op(v);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
